// File: rtl/sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_arbiter
// Brief    : Shares the 16-bit CPU system bus between the 6502 core (default
//            owner), the OAM DMA engine and the cartridge/RAM loader. A single
//            turnaround cycle separates every ownership change. The CPU is
//            stalled through RDY whenever it does not own the bus.
//            Optional CPU stall statistics: define SYSBUS_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sysbus_arbiter #(
    parameter int unsigned HOLD_MAX = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_rw,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_rdy,
    input  logic              dma_req,
    input  logic [15:0]       dma_addr,
    input  logic              dma_rw,
    input  logic [7:0]        dma_wdata,
    output logic              dma_gnt,
    input  logic              ldr_req,
    input  logic [15:0]       ldr_addr,
    input  logic              ldr_rw,
    input  logic [7:0]        ldr_wdata,
    output logic              ldr_gnt,
    output logic [15:0]       bus_addr,
    output logic              bus_rw,
    output logic [7:0]        bus_wdata,
    output logic              bus_valid,
    output logic [1:0]        owner
`ifdef SYSBUS_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    // Hold counter only needs to reach HOLD_MAX-1; keep at least one bit.
    localparam int unsigned HOLD_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : HOLD_W'(HOLD_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    // State encoding doubles as the owner code.
    typedef enum logic [1:0] {
        OWN_CPU = 2'd0,
        OWN_DMA = 2'd1,
        OWN_LDR = 2'd2,
        TURN    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_hit;
    logic              rev_dma;
    logic              rev_ldr;
    logic              revoke_dma;
    logic              revoke_ldr;

    // Elaboration guard on the parameter ranges.
    if (CNT_W < 1) begin : g_param_check
        $error("sysbus_arbiter: CNT_W must be at least 1");
    end

    // A bounded tenure has used up its slot once the counter sits at HOLD_MAX-1.
    assign hold_hit = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST);

    // Next-state selection and revoke decisions.
    always_comb begin
        state_nxt  = state;
        revoke_dma = 1'b0;
        revoke_ldr = 1'b0;
        case (state)
            OWN_CPU: begin
                if (dma_req || ldr_req) state_nxt = TURN;
            end
            TURN: begin
                if (dma_req && !rev_dma) state_nxt = OWN_DMA;
                else if (ldr_req)        state_nxt = OWN_LDR;
                else if (dma_req)        state_nxt = OWN_DMA;
                else                     state_nxt = OWN_CPU;
            end
            OWN_DMA: begin
                if (!dma_req) begin
                    state_nxt = TURN;
                end else if (hold_hit && ldr_req) begin
                    state_nxt  = TURN;
                    revoke_dma = 1'b1;
                end
            end
            OWN_LDR: begin
                if (!ldr_req) begin
                    state_nxt = TURN;
                end else if (hold_hit && dma_req) begin
                    state_nxt  = TURN;
                    revoke_ldr = 1'b1;
                end
            end
            default: state_nxt = OWN_CPU;
        endcase
    end

    // State, hold counter and revoke flags; reset abandons any tenure at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= OWN_CPU;
            hold_cnt <= '0;
            rev_dma  <= 1'b0;
            rev_ldr  <= 1'b0;
        end else begin
            state <= state_nxt;
            // Every tenure is entered from TURN, so clearing there starts it at 0.
            // The counter parks at HOLD_MAX-1 so a late competing request is
            // served on the next cycle instead of after a wrap.
            if (state == TURN) begin
                hold_cnt <= '0;
            end else if ((state == OWN_DMA || state == OWN_LDR) && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + HOLD_ONE;
            end
            if (revoke_dma) begin
                rev_dma <= 1'b1;
            end else if (state == TURN && state_nxt == OWN_LDR) begin
                rev_dma <= 1'b0;
            end
            if (revoke_ldr) begin
                rev_ldr <= 1'b1;
            end else if (state == TURN && state_nxt == OWN_DMA) begin
                rev_ldr <= 1'b0;
            end
        end
    end

    assign owner   = state;
    assign cpu_rdy = (state == OWN_CPU);
    assign dma_gnt = (state == OWN_DMA);
    assign ldr_gnt = (state == OWN_LDR);

    // Bus mux selected by the current owner; TURN drives an idle read of 0.
    always_comb begin
        bus_addr  = 16'h0000;
        bus_rw    = 1'b1;
        bus_wdata = 8'h00;
        bus_valid = 1'b1;
        case (state)
            OWN_CPU: begin
                bus_addr  = cpu_addr;
                bus_rw    = cpu_rw;
                bus_wdata = cpu_wdata;
            end
            OWN_DMA: begin
                bus_addr  = dma_addr;
                bus_rw    = dma_rw;
                bus_wdata = dma_wdata;
            end
            OWN_LDR: begin
                bus_addr  = ldr_addr;
                bus_rw    = ldr_rw;
                bus_wdata = ldr_wdata;
            end
            default: bus_valid = 1'b0;
        endcase
    end

`ifdef SYSBUS_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturating count of cycles in which the CPU is held off the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!cpu_rdy && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysbus_arbiter
// Brief    : Self-checking bench for sysbus_arbiter: directed scenarios with
//            literal expectations plus randomized traffic compared every cycle
//            against a tenure-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysbus_arbiter;

    localparam int HOLD = 4;
    localparam int CNTW = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rw = 1'b1;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_rdy;
    logic        dma_req = 1'b0;
    logic [15:0] dma_addr = '0;
    logic        dma_rw = 1'b1;
    logic [7:0]  dma_wdata = '0;
    logic        dma_gnt;
    logic        ldr_req = 1'b0;
    logic [15:0] ldr_addr = '0;
    logic        ldr_rw = 1'b1;
    logic [7:0]  ldr_wdata = '0;
    logic        ldr_gnt;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_wdata;
    logic        bus_valid;
    logic [1:0]  owner;
`ifdef SYSBUS_ARB_STATS_EN
    logic [CNTW-1:0] stall_cnt;
`endif

    sysbus_arbiter #(.HOLD_MAX(HOLD), .CNT_W(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_rw(dma_rw), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_rw(ldr_rw), .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt),
        .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_wdata(bus_wdata), .bus_valid(bus_valid),
        .owner(owner)
`ifdef SYSBUS_ARB_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (0 CPU, 1 DMA, 2 loader, 3 turnaround),
    // how many cycles the current tenure has lasted, who was last revoked,
    // and how many stalled cycles the CPU has seen.
    int m_owner = 0;
    int m_held  = 0;
    bit m_rev_dma = 1'b0;
    bit m_rev_ldr = 1'b0;
    int m_stall = 0;
    int n_owner, n_held, n_stall;
    bit n_rev_dma, n_rev_ldr;

    // Advance the model by one clock using the requests presented at the edge.
    always @(posedge clk) begin
        n_owner = m_owner; n_held = m_held; n_stall = m_stall;
        n_rev_dma = m_rev_dma; n_rev_ldr = m_rev_ldr;
        if (!rst_n) begin
            n_owner = 0; n_held = 0; n_stall = 0; n_rev_dma = 0; n_rev_ldr = 0;
        end else begin
            if (m_owner != 0 && m_stall < (1 << CNTW) - 1) n_stall = m_stall + 1;
            if (m_owner == 0) begin
                if (dma_req || ldr_req) n_owner = 3;
            end else if (m_owner == 3) begin
                if (dma_req && !m_rev_dma) n_owner = 1;
                else if (ldr_req)          n_owner = 2;
                else if (dma_req)          n_owner = 1;
                else                       n_owner = 0;
                n_held = 1;
                if (n_owner == 1) n_rev_ldr = 0;
                if (n_owner == 2) n_rev_dma = 0;
            end else begin
                // own = requester holding the bus, other = competing requester
                if (!(m_owner == 1 ? dma_req : ldr_req)) begin
                    n_owner = 3;
                end else if (m_held >= HOLD && (m_owner == 1 ? ldr_req : dma_req)) begin
                    n_owner = 3;
                    if (m_owner == 1) n_rev_dma = 1; else n_rev_ldr = 1;
                end else begin
                    n_held = m_held + 1;
                end
            end
        end
        m_owner   <= n_owner;
        m_held    <= n_held;
        m_stall   <= n_stall;
        m_rev_dma <= n_rev_dma;
        m_rev_ldr <= n_rev_ldr;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            logic [15:0] e_addr;
            logic        e_rw;
            logic [7:0]  e_wd;
            case (m_owner)
                0:       begin e_addr = cpu_addr; e_rw = cpu_rw; e_wd = cpu_wdata; end
                1:       begin e_addr = dma_addr; e_rw = dma_rw; e_wd = dma_wdata; end
                2:       begin e_addr = ldr_addr; e_rw = ldr_rw; e_wd = ldr_wdata; end
                default: begin e_addr = 16'h0000; e_rw = 1'b1;   e_wd = 8'h00;     end
            endcase
            chk("owner",     owner,     m_owner);
            chk("cpu_rdy",   cpu_rdy,   m_owner == 0);
            chk("dma_gnt",   dma_gnt,   m_owner == 1);
            chk("ldr_gnt",   ldr_gnt,   m_owner == 2);
            chk("bus_valid", bus_valid, m_owner != 3);
            chk("bus_addr",  bus_addr,  e_addr);
            chk("bus_rw",    bus_rw,    e_rw);
            chk("bus_wdata", bus_wdata, e_wd);
`ifdef SYSBUS_ARB_STATS_EN
            chk("stall_cnt", stall_cnt, m_stall);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int hold_seq[12] = '{3, 1, 1, 1, 1, 3, 2, 2, 2, 2, 3, 1};

    initial begin
        // Reset held for two cycles while DMA requests.
        rst_n = 1'b0; dma_req = 1'b1;
        step();
        check_en = 1'b1;
        step();
        chk("rst_owner", owner, 0);
        chk("rst_cpu_rdy", cpu_rdy, 1);
        chk("rst_dma_gnt", dma_gnt, 0);
`ifdef SYSBUS_ARB_STATS_EN
        chk("rst_stall", stall_cnt, 0);
`endif
        rst_n = 1'b1;
        step();
        chk("rel_turn", owner, 3);
        step();
        chk("rel_grant", dma_gnt, 1);

        // 513-cycle DMA burst interleaving OAM source reads and 0x2004 writes.
        for (int i = 0; i < 513; i++) begin
            dma_addr  = (i % 2 == 0) ? 16'h0200 + 16'((i / 2) % 256) : 16'h2004;
            dma_rw    = (i % 2 == 0);
            dma_wdata = 8'(i);
            if (i == 512) dma_req = 1'b0;
            step();
        end
        chk("burst_turn", owner, 3);
        step();
        chk("burst_end_owner", owner, 0);
        chk("burst_end_rdy", cpu_rdy, 1);
`ifdef SYSBUS_ARB_STATS_EN
        chk("burst_stall", stall_cnt, 515);
`endif

        // Simultaneous requests: DMA first, loader after DMA releases.
        dma_req = 1'b1; ldr_req = 1'b1;
        step(); chk("prio_turn", owner, 3);
        step(); chk("prio_dma", dma_gnt, 1); chk("prio_no_ldr", ldr_gnt, 0);
        dma_req = 1'b0;
        step(); chk("prio_turn2", owner, 3);
        step(); chk("prio_ldr", ldr_gnt, 1);
        ldr_req = 1'b0;
        step(); step(); chk("prio_back_cpu", owner, 0);

        // Hold limit alternation with both masters requesting continuously.
        dma_req = 1'b1; ldr_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("hold_seq", owner, hold_seq[i]);
        end
        dma_req = 1'b0; ldr_req = 1'b0;
        step(); chk("hold_turn", owner, 3);
        step(); chk("hold_cpu", owner, 0);

        // One-cycle loader pulse with an OAM-DMA write pending on the CPU bus.
        cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_wdata = 8'h02;
        ldr_req = 1'b1;
        step();
        chk("wd_turn", owner, 3);
        chk("wd_turn_addr", bus_addr, 16'h0000);
        chk("wd_turn_rw", bus_rw, 1);
        chk("wd_turn_valid", bus_valid, 0);
        ldr_req = 1'b0;
        step();
        chk("wd_cpu", owner, 0);
        chk("wd_no_gnt", ldr_gnt, 0);
        #1;
        chk("wd_cpu_addr", bus_addr, 16'h4014);

        // Randomized traffic with sticky level requests and one mid-run reset.
        for (int i = 0; i < 4000; i++) begin
            rst_n     = !(i == 2000 || i == 2001);
            if ($urandom_range(7) == 0) dma_req = ~dma_req;
            if ($urandom_range(7) == 0) ldr_req = ~ldr_req;
            cpu_addr  = 16'($urandom); cpu_rw = 1'($urandom); cpu_wdata = 8'($urandom);
            dma_addr  = 16'($urandom); dma_rw = 1'($urandom); dma_wdata = 8'($urandom);
            ldr_addr  = 16'($urandom); ldr_rw = 1'($urandom); ldr_wdata = 8'($urandom);
            step();
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
